// File: rtl/sync_fifo_flagged_if.sv
// Write/read/control bundle between a producer/consumer and the flagged FIFO.
interface sync_fifo_flagged_if #(
  parameter int WIDTH   = 32,
  parameter int W_LEVEL = 4
);
  logic [WIDTH-1:0]   w_data;
  logic               w_en;
  logic [WIDTH-1:0]   r_data;
  logic               r_en;
  logic               flush;
  logic [W_LEVEL-1:0] af_thresh;
  logic [W_LEVEL-1:0] ae_thresh;
  logic               full;
  logic               empty;
  logic               almost_full;
  logic               almost_empty;
  logic [W_LEVEL-1:0] level;
  logic               overflow;
  logic               underflow;

  // Client side: drives requests and thresholds, observes data and status.
  modport master (
    output w_data, w_en, r_en, flush, af_thresh, ae_thresh,
    input  r_data, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

  // FIFO side.
  modport slave (
    input  w_data, w_en, r_en, flush, af_thresh, ae_thresh,
    output r_data, full, empty, almost_full, almost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flagged_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one combinational read port.
// Deliberately reset-free so it can map onto distributed RAM.
module sync_fifo_flagged_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int W_PTR = 3
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [W_PTR-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [W_PTR-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: store the pushed word at the write pointer.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_flagged.sv
// Pointer-addressed first-word-fall-through FIFO with flush, programmable
// watermarks and sticky overflow/underflow flags. All flags are registered
// from the next-state level so they move in the same cycle as level.
module sync_fifo_flagged #(
  parameter int DEPTH   = 8,
  parameter int WIDTH   = 32,
  parameter int W_LEVEL = $clog2(DEPTH + 1)
) (
  input logic               clk,
  input logic               rst,
  sync_fifo_flagged_if.slave bus
);
  localparam int W_PTR = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Last valid pointer value; with DEPTH = 1 this is 0 and the pointers stay 0.
  localparam logic [W_PTR-1:0]   PTR_LAST = W_PTR'(DEPTH - 1);
  localparam logic [W_LEVEL-1:0] LVL_MAX  = W_LEVEL'(DEPTH);

  logic [W_PTR-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [W_LEVEL-1:0] level_q, level_d;
  logic full_q, full_d, empty_q, empty_d;
  logic af_q, af_d, ae_q, ae_d;
  logic ovf_q, ovf_d, udf_q, udf_d;
  logic push, pop;

  // Explicit wrap so non-power-of-2 depths never address past the array.
  function automatic logic [W_PTR-1:0] ptr_inc(input logic [W_PTR-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Handshake and next-state; flush overrides any same-cycle request.
  always_comb begin
    pop     = bus.r_en && !empty_q && !bus.flush;
    push    = bus.w_en && (!full_q || pop) && !bus.flush;
    wptr_d  = bus.flush ? '0 : (push ? ptr_inc(wptr_q) : wptr_q);
    rptr_d  = bus.flush ? '0 : (pop  ? ptr_inc(rptr_q) : rptr_q);
    level_d = bus.flush ? '0 : level_q + W_LEVEL'(push) - W_LEVEL'(pop);
    full_d  = (level_d == LVL_MAX);
    empty_d = (level_d == '0);
    // Thresholds are sampled every cycle, so a change lands on the next edge.
    af_d    = (level_d >= bus.af_thresh);
    ae_d    = (level_d <= bus.ae_thresh);
    ovf_d   = bus.flush ? 1'b0 : (ovf_q | (bus.w_en && full_q && !bus.r_en));
    udf_d   = bus.flush ? 1'b0 : (udf_q | (bus.r_en && empty_q));
  end

  // Pointer, level, flag and sticky-error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  sync_fifo_flagged_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .W_PTR (W_PTR)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i (bus.w_data),
    .raddr_i (rptr_q),
    .rdata_o (bus.r_data)
  );

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.level        = level_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Two FIFOs (DEPTH 8 and DEPTH 5) each checked every cycle against a queue model,
// plus directed sequences with hand-computed expectations.
module tb_sync_fifo_flagged;
  logic clk, rst;
  int   n_chk = 0, n_err = 0;

  // Per-instance stimulus and observed outputs (index 0: DEPTH 8, 1: DEPTH 5).
  logic        w_en_s[2], r_en_s[2], fl_s[2];
  logic [31:0] wd_s[2];
  int          af_s[2], ae_s[2];
  logic [31:0] rd_o[2];
  int          lvl_o[2];
  logic        full_o[2], empty_o[2], af_o[2], ae_o[2], ov_o[2], un_o[2];
  int          msize[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int g, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s[%0d] got %0h expected %0h at %0t", nm, g, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen
    localparam int D  = (g == 0) ? 8 : 5;
    localparam int WL = $clog2(D + 1);

    sync_fifo_flagged_if #(.WIDTH(32), .W_LEVEL(WL)) ifc ();

    assign ifc.w_data    = wd_s[g];
    assign ifc.w_en      = w_en_s[g];
    assign ifc.r_en      = r_en_s[g];
    assign ifc.flush     = fl_s[g];
    assign ifc.af_thresh = WL'(af_s[g]);
    assign ifc.ae_thresh = WL'(ae_s[g]);
    assign rd_o[g]    = ifc.r_data;
    assign lvl_o[g]   = int'(ifc.level);
    assign full_o[g]  = ifc.full;
    assign empty_o[g] = ifc.empty;
    assign af_o[g]    = ifc.almost_full;
    assign ae_o[g]    = ifc.almost_empty;
    assign ov_o[g]    = ifc.overflow;
    assign un_o[g]    = ifc.underflow;

    sync_fifo_flagged #(.DEPTH(D), .WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
    );

    // Behavioural model: a queue plus sticky bits; flags from occupancy rules.
    logic [31:0] q[$];
    bit ov, un, eaf, eae, popv, pushv;
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        q.delete(); ov = 0; un = 0; eaf = 0; eae = 1;
      end else begin
        if (fl_s[g]) begin
          q.delete(); ov = 0; un = 0;
        end else begin
          popv  = r_en_s[g] && (q.size() != 0);
          pushv = w_en_s[g] && ((q.size() < D) || popv);
          if (w_en_s[g] && q.size() == D && !r_en_s[g]) ov = 1;
          if (r_en_s[g] && q.size() == 0) un = 1;
          if (popv) void'(q.pop_front());
          if (pushv) q.push_back(wd_s[g]);
        end
        eaf = int'(q.size()) >= af_s[g];
        eae = int'(q.size()) <= ae_s[g];
      end
      msize[g] = int'(q.size());
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
      if (!rst) begin
        chk("level", g, lvl_o[g], q.size());
        chk("empty", g, empty_o[g], q.size() == 0);
        chk("full", g, full_o[g], q.size() == D);
        chk("almost_full", g, af_o[g], eaf);
        chk("almost_empty", g, ae_o[g], eae);
        chk("overflow", g, ov_o[g], ov);
        chk("underflow", g, un_o[g], un);
        if (q.size() != 0) chk("r_data", g, rd_o[g], q[0]);
      end
    end
  end

  task automatic idle_all();
    for (int g = 0; g < 2; g++) begin
      w_en_s[g] = 0; r_en_s[g] = 0; fl_s[g] = 0; wd_s[g] = '0;
    end
  endtask

  // One cycle on instance g; outputs are stable at the returning negedge.
  task automatic cyc(input int g, input bit we, input bit re, input logic [31:0] wd, input bit fl);
    w_en_s[g] = we; r_en_s[g] = re; wd_s[g] = wd; fl_s[g] = fl;
    @(negedge clk);
    w_en_s[g] = 0; r_en_s[g] = 0; fl_s[g] = 0;
  endtask

  initial begin
    idle_all();
    af_s[0] = 6; ae_s[0] = 1; af_s[1] = 4; ae_s[1] = 1;
    rst = 1;
    #1;
    chk("rst_level", 0, lvl_o[0], 0);
    chk("rst_empty", 0, empty_o[0], 1);
    chk("rst_full", 0, full_o[0], 0);
    chk("rst_af", 0, af_o[0], 0);
    chk("rst_ae", 0, ae_o[0], 1);
    chk("rst_ov_un", 0, {ov_o[0], un_o[0]}, 0);
    @(negedge clk);
    rst = 0;

    // Fill 0..7 and watch watermarks (af=6, ae=1).
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 32'(i), 0);
      chk("fill_af", 0, af_o[0], (i + 1) >= 6);
      chk("fill_ae", 0, ae_o[0], (i + 1) <= 1);
    end
    chk("fill_level", 0, lvl_o[0], 8);
    chk("fill_model", 0, msize[0], 8);
    chk("fill_full", 0, full_o[0], 1);
    chk("fill_head", 0, rd_o[0], 0);
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", 0, rd_o[0], i);
      cyc(0, 0, 1, 0, 0);
    end
    chk("drain_empty", 0, empty_o[0], 1);

    // Push+pop while full is accepted.
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 32'h10 + 32'(i), 0);
    cyc(0, 1, 1, 32'hAA, 0);
    chk("fullpp_level", 0, lvl_o[0], 8);
    chk("fullpp_ov", 0, ov_o[0], 0);
    chk("fullpp_head", 0, rd_o[0], 32'h11);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0, 0);
    chk("last_level", 0, lvl_o[0], 1);
    chk("last_data", 0, rd_o[0], 32'hAA);
    cyc(0, 0, 1, 0, 0);

    // af_thresh = 0 forces almost_full on the next edge.
    af_s[0] = 0;
    cyc(0, 0, 0, 0, 0);
    chk("af0", 0, af_o[0], 1);
    af_s[0] = 6;
    cyc(0, 0, 0, 0, 0);

    // Underflow, overflow, flush.
    cyc(0, 0, 1, 0, 0);
    chk("udf", 0, un_o[0], 1);
    chk("udf_level", 0, lvl_o[0], 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 32'h20 + 32'(i), 0);
    cyc(0, 1, 0, 32'h99, 0);
    chk("ovf", 0, ov_o[0], 1);
    chk("ovf_level", 0, lvl_o[0], 8);
    chk("ovf_head", 0, rd_o[0], 32'h20);
    cyc(0, 1, 1, 32'h77, 1);
    chk("flush_flags", 0, {ov_o[0], un_o[0]}, 0);
    chk("flush_empty", 0, empty_o[0], 1);
    chk("flush_level", 0, lvl_o[0], 0);
    w_en_s[0] = 1; fl_s[0] = 1; wd_s[0] = 32'h33;
    @(negedge clk); @(negedge clk);
    idle_all();
    chk("flush_hold", 0, lvl_o[0], 0);

    // DEPTH 5: 23 push/pop pairs at level 2 across pointer wrap.
    cyc(1, 1, 0, 100, 0);
    cyc(1, 1, 0, 101, 0);
    for (int k = 0; k < 23; k++) begin
      cyc(1, 1, 1, 32'(102 + k), 0);
      chk("wrap_level", 1, lvl_o[1], 2);
      chk("wrap_head", 1, rd_o[1], 101 + k);
    end
    for (int k = 0; k < 2; k++) cyc(1, 0, 1, 0, 0);

    // Asynchronous reset mid-cycle with flags set.
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 32'(i), 0);
    chk("pre_rst_level", 0, lvl_o[0], 3);
    #2 rst = 1;
    #1;
    chk("arst_level", 0, lvl_o[0], 0);
    chk("arst_empty", 0, empty_o[0], 1);
    chk("arst_flags", 0, {ov_o[0], un_o[0]}, 0);
    @(negedge clk);
    rst = 0;
    cyc(0, 1, 0, 32'h55, 0);
    chk("post_rst_data", 0, rd_o[0], 32'h55);
    chk("post_rst_empty", 0, empty_o[0], 0);

    // Randomized traffic on both instances, checked by the models.
    for (int n = 0; n < 1500; n++) begin
      for (int g = 0; g < 2; g++) begin
        w_en_s[g] = ($urandom_range(0, 99) < 55);
        r_en_s[g] = ($urandom_range(0, 99) < 50);
        fl_s[g]   = ($urandom_range(0, 59) == 0);
        wd_s[g]   = $urandom;
        if ($urandom_range(0, 49) == 0) begin
          af_s[g] = $urandom_range(0, (g == 0) ? 9 : 6);
          ae_s[g] = $urandom_range(0, (g == 0) ? 9 : 6);
        end
      end
      @(negedge clk);
    end
    idle_all();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
